decode_stage: RTL

Registered, parametrised instruction-decode stage for the SIMD processor pipeline. It sits between fetch and execute and accepts one instruction per cycle over a valid/ready handshake. It decodes the opcode class into the control word, latches that word in an ID/EX output register, and holds back conditional jumps while an NZ-flag writer is still in flight. It replaces the purely combinational decode path with a stallable, flushable stage whose width, register-file split and immediate extension are parameters.

---
 rtl/decode_pkg.sv | 27 ++
 rtl/decode_if.sv | 35 +++
 rtl/ctrl_decode.sv | 61 ++++++
 rtl/decode_stage.sv | 94 +++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared opcode encodings, WriteRegFrom encodings and the fixed-width control word
// used by the instruction-decode stage.
package decode_pkg;

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_JMP   = 4'b1000;
  localparam logic [3:0] OP_JCOND = 4'b1001;
  localparam logic [3:0] OP_STORE = 4'b1100;
  localparam logic [3:0] OP_LOAD  = 4'b1101;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  localparam logic [1:0] WRF_MEM = 2'b00;
  localparam logic [1:0] WRF_ALU = 2'b01;
  localparam logic [1:0] WRF_PC  = 2'b10;

  typedef struct packed {
    logic       memory_write;
    logic [1:0] write_reg_from;
    logic       write_mem_from;
    logic       reg_write_en_sc;
    logic       reg_write_en_vec;
    logic [2:0] pc_write_en;
    logic       over_write_nz;
    logic [2:0] alu_op_code;
  } ctrl_word_t;

endpackage

// File: rtl/decode_if.sv
// Fetch-side and execute-side handshake plus the registered control word of the decode stage.
interface decode_if #(
  parameter int N        = 24,
  parameter int REG_W    = 4,
  parameter int REG_SIZE = 32
);
  logic                in_valid;
  logic [N-1:0]        in_instr;
  logic                in_ready;
  logic                flush;
  logic                out_valid;
  logic                out_ready;
  logic                MemoryWrite;
  logic [1:0]          WriteRegFrom;
  logic [REG_W-1:0]    RegToWrite;
  logic [REG_SIZE-1:0] Immediate;
  logic                writeMemFrom;
  logic                RegWriteEnSc;
  logic                RegWriteEnVec;
  logic [2:0]          PcWriteEn;
  logic                OverWriteNz;
  logic [2:0]          AluOpCode;

  modport slave (
    input  in_valid, in_instr, flush, out_ready,
    output in_ready, out_valid, MemoryWrite, WriteRegFrom, RegToWrite, Immediate,
           writeMemFrom, RegWriteEnSc, RegWriteEnVec, PcWriteEn, OverWriteNz, AluOpCode
  );

  modport master (
    output in_valid, in_instr, flush, out_ready,
    input  in_ready, out_valid, MemoryWrite, WriteRegFrom, RegToWrite, Immediate,
           writeMemFrom, RegWriteEnSc, RegWriteEnVec, PcWriteEn, OverWriteNz, AluOpCode
  );
endinterface

// File: rtl/ctrl_decode.sv
// Purely combinational opcode-to-control mapping, destination index split and
// immediate extension.
module ctrl_decode
  import decode_pkg::*;
#(
  parameter int N            = 24,
  parameter int REG_W        = 4,
  parameter int REG_SIZE     = 32,
  parameter int VEC_REGS     = 4,
  parameter int SIGN_EXT_IMM = 0
) (
  input  logic [N-1:0]        instr,
  output ctrl_word_t          ctrl,
  output logic [REG_W-1:0]    reg_idx,
  output logic [REG_SIZE-1:0] imm
);

  localparam int IMM_W = N - 4 - REG_W;
  localparam logic [REG_W:0] VEC_LIM = (REG_W + 1)'(VEC_REGS);

  logic [3:0]              op;
  logic [IMM_W-1:0]        imm_raw;
  logic signed [IMM_W-1:0] imm_s;
  logic                    reg_write_en;
  logic                    is_vec;

  assign op      = instr[N-1:N-4];
  assign reg_idx = instr[N-5:N-4-REG_W];
  assign imm_raw = instr[IMM_W-1:0];
  assign imm_s   = imm_raw;
  assign is_vec  = ({1'b0, reg_idx} < VEC_LIM);

  always_comb begin
    ctrl              = '0;
    reg_write_en      = ~op[3] | (op == OP_LOAD) | (op == OP_HALT);
    ctrl.alu_op_code  = op[2:0];
    ctrl.pc_write_en  = {op == OP_JCOND, op == OP_JMP, op == OP_HALT};
    ctrl.memory_write = (op == OP_STORE);
    ctrl.write_mem_from = (op[3:1] == 3'b110);
    ctrl.over_write_nz  = ~op[3] & (op[2:0] != 3'b000);
    // NOP and the jump group both route the PC path; other 0xxx are ALU results.
    if (op == OP_NOP || op[3:2] == 2'b10) begin
      ctrl.write_reg_from = WRF_PC;
    end else if (!op[3]) begin
      ctrl.write_reg_from = WRF_ALU;
    end else begin
      ctrl.write_reg_from = WRF_MEM;
    end
    ctrl.reg_write_en_vec = reg_write_en & is_vec;
    ctrl.reg_write_en_sc  = reg_write_en & ~is_vec;
  end

  generate
    if (SIGN_EXT_IMM != 0) begin : g_sext
      assign imm = REG_SIZE'(imm_s);
    end else begin : g_zext
      assign imm = REG_SIZE'(imm_raw);
    end
  endgenerate

endmodule

// File: rtl/decode_stage.sv
// Registered, stallable and flushable instruction-decode stage with an NZ-flag
// scoreboard that holds back conditional jumps until the flags are valid.
module decode_stage
  import decode_pkg::*;
#(
  parameter int N            = 24,
  parameter int REG_W        = 4,
  parameter int REG_SIZE     = 32,
  parameter int VEC_REGS     = 4,
  parameter int FLAG_LAT     = 2,
  parameter int SIGN_EXT_IMM = 0
) (
  input  logic     clk,
  input  logic     rst,
  decode_if.slave  bus
);

  localparam int CNT_W = $clog2(FLAG_LAT + 1);
  localparam logic [CNT_W-1:0] FLAG_LOAD = CNT_W'(FLAG_LAT);

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  ctrl_word_t          ctrl_p0, ctrl_p1;
  logic [REG_W-1:0]    idx_p0, idx_p1;
  logic [REG_SIZE-1:0] imm_p0, imm_p1;
  logic                vld_p1;
  logic [CNT_W-1:0]    flag_cnt;
  logic                hazard, xfer_in, xfer_out;

  // ---- stage p0: combinational decode of the incoming word ----
  ctrl_decode #(
    .N            (N),
    .REG_W        (REG_W),
    .REG_SIZE     (REG_SIZE),
    .VEC_REGS     (VEC_REGS),
    .SIGN_EXT_IMM (SIGN_EXT_IMM)
  ) u_ctrl_decode (
    .instr   (bus.in_instr),
    .ctrl    (ctrl_p0),
    .reg_idx (idx_p0),
    .imm     (imm_p0)
  );

  // A held NZ writer has not left yet, so its flags are not even scheduled.
  assign hazard = bus.in_valid & (bus.in_instr[N-1:N-4] == OP_JCOND)
                & ((flag_cnt != '0) | (vld_p1 & ctrl_p1.over_write_nz));

  assign bus.in_ready = (~vld_p1 | bus.out_ready) & ~bus.flush & ~hazard & ~rst;
  assign xfer_in      = bus.in_valid & bus.in_ready;
  assign xfer_out     = vld_p1 & bus.out_ready & ~bus.flush;

  // ---- stage p1: ID/EX output register and flag scoreboard ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      ctrl_p1  <= '0;
      idx_p1   <= '0;
      imm_p1   <= '0;
      flag_cnt <= '0;
    end else begin
      if (bus.flush) begin
        vld_p1 <= 1'b0;
      end else if (xfer_in) begin
        vld_p1  <= 1'b1;
        ctrl_p1 <= ctrl_p0;
        idx_p1  <= idx_p0;
        imm_p1  <= imm_p0;
      end else if (xfer_out) begin
        vld_p1 <= 1'b0;
      end

      if (xfer_out && ctrl_p1.over_write_nz) begin
        flag_cnt <= FLAG_LOAD;
      end else begin
        flag_cnt <= sat_dec(flag_cnt);
      end
    end
  end

  assign bus.out_valid     = vld_p1;
  assign bus.MemoryWrite   = ctrl_p1.memory_write;
  assign bus.WriteRegFrom  = ctrl_p1.write_reg_from;
  assign bus.RegToWrite    = idx_p1;
  assign bus.Immediate     = imm_p1;
  assign bus.writeMemFrom  = ctrl_p1.write_mem_from;
  assign bus.RegWriteEnSc  = ctrl_p1.reg_write_en_sc;
  assign bus.RegWriteEnVec = ctrl_p1.reg_write_en_vec;
  assign bus.PcWriteEn     = ctrl_p1.pc_write_en;
  assign bus.OverWriteNz   = ctrl_p1.over_write_nz;
  assign bus.AluOpCode     = ctrl_p1.alu_op_code;

endmodule
